// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) with a show-ahead
//            byte FIFO and one-cycle frame/parity/overflow error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
  parameter int unsigned BPS_PARA   = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       RXD,
  output logic [7:0] data_o,
  output logic       empty_o,
  input  logic       rd_en_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int unsigned TMR_W = $clog2(BPS_PARA);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(BPS_PARA / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(BPS_PARA - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  logic [1:0]       sync_q;
  logic             rxs;
  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;
  logic             bit_tick;
  logic             byte_ok;
  logic             push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RXD};
  end
  assign rxs = sync_q[1];

  assign bit_tick = (timer_q == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic bad_q;
  logic parity_err_q;
  assign byte_ok      = !bad_q;
  assign parity_err_o = parity_err_q;
`else
  assign byte_ok      = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  assign push = (state_q == S_STOP) && bit_tick && rxs && byte_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        // IDLE is only entered with rxs high, so a low level here is a start edge.
        S_IDLE: begin
          timer_q <= '0;
          if (!rxs) begin
            state_q <= S_START;
`ifdef UART_RX_PARITY_EN
            bad_q   <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (timer_q == HALF_M1) begin
            timer_q  <= '0;
            bitcnt_q <= '0;
            state_q  <= rxs ? S_IDLE : S_DATA;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            timer_q  <= '0;
            shift_q  <= {rxs, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            timer_q <= '0;
            bad_q   <= ^{shift_q, rxs};
            state_q <= S_STOP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            timer_q <= '0;
            if (!rxs) begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err_q <= bad_q;
`endif
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          timer_q <= '0;
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != S_IDLE);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             overflow_q;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full    = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign pop     = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !pop;
      if (push_ok) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o     = mem_q[rd_q];
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Directed self-checking bench for uart_rx_frame (BPS 16, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

  localparam int BPS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Negedges from the RXD start edge to the first negedge showing the push.
  localparam int PUSH_NEG = 11 + BPS * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       RXD = 1'b1;
  logic       rd_en_i = 1'b0;
  logic [7:0] data_o;
  logic       empty_o, frame_err_o, parity_err_o, overflow_o, busy_o;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_frame #(.BPS_PARA(BPS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .RXD(RXD), .data_o(data_o), .empty_o(empty_o),
    .rd_en_i(rd_en_i), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err_o)  fe_cnt++;
    if (parity_err_o) pe_cnt++;
    if (overflow_o)   ov_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    @(negedge clk);
    rd_en_i = 1'b0;
  endtask

  // Drives one frame starting now; leaves RXD at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    RXD = 1'b0;
    idle(BPS);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      idle(BPS);
    end
`ifdef UART_RX_PARITY_EN
    RXD = (^d) ^ par_flip;
    idle(BPS);
`endif
    RXD = stop_bit;
    idle(BPS);
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++;
    if ({frame_err_o, parity_err_o, overflow_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {frame_err_o, parity_err_o, overflow_o});
    end
    rstn = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int e0;
    e0 = fe_cnt + pe_cnt + ov_cnt;
    @(negedge clk);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle(PUSH_NEG - 1);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_early got empty %b want 1", empty_o); end
        idle(1);
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL basic_push got empty %b want 0", empty_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", data_o); end
      end
    join
    idle(4);
    checks++; if (fe_cnt + pe_cnt + ov_cnt !== e0) begin errors++; $display("FAIL basic_noerr got %0d want %0d", fe_cnt + pe_cnt + ov_cnt, e0); end
    pop();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_pop got empty %b want 1", empty_o); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = fe_cnt + pe_cnt + ov_cnt;
    @(negedge clk);
    RXD = 1'b0;
    idle(4);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", busy_o); end
    idle(1);
    RXD = 1'b1;
    idle(30);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", busy_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL glitch_nobyte got empty %b want 1", empty_o); end
    checks++; if (fe_cnt + pe_cnt + ov_cnt !== e0) begin errors++; $display("FAIL glitch_noerr got %0d want %0d", fe_cnt + pe_cnt + ov_cnt, e0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    idle(100);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy got %b want 1", busy_o); end
    checks++; if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d want %0d", fe_cnt, f0 + 1); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ferr_discard got empty %b want 1", empty_o); end
    RXD = 1'b1;
    idle(20);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_release got %b want 0", busy_o); end
    send_frame(8'h81, 1'b1);
    idle(4);
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL ferr_next_empty got %b want 0", empty_o); end
    checks++; if (data_o !== 8'h81) begin errors++; $display("FAIL ferr_next_data got %h want 81", data_o); end
    checks++; if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_single got %0d want %0d", fe_cnt, f0 + 1); end
    pop();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ferr_drain got empty %b want 1", empty_o); end
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] exp;
    o0 = ov_cnt;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    idle(4);
    checks++; if (ov_cnt !== o0 + 1) begin errors++; $display("FAIL ovf_pulse got %0d want %0d", ov_cnt, o0 + 1); end
    for (int k = 1; k <= 4; k++) begin
      exp = 8'(k);
      checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL ovf_empty%0d got %b want 0", k, empty_o); end
      checks++; if (data_o !== exp) begin errors++; $display("FAIL ovf_data%0d got %h want %h", k, data_o, exp); end
      pop();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b want 1", empty_o); end
  endtask

  task automatic test_full_pop();
    int o0;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h77;
    o0 = ov_cnt;
    @(negedge clk);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    fork
      send_frame(8'h77, 1'b1);
      begin
        idle(PUSH_NEG - 1);
        rd_en_i = 1'b1;
        idle(1);
        rd_en_i = 1'b0;
      end
    join
    idle(4);
    checks++; if (ov_cnt !== o0) begin errors++; $display("FAIL fullpop_noovf got %0d want %0d", ov_cnt, o0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (data_o !== exp_q[k]) begin errors++; $display("FAIL fullpop_data%0d got %h want %h", k, data_o, exp_q[k]); end
      pop();
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fullpop_drained got %b want 1", empty_o); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0, f0;
    p0 = pe_cnt;
    f0 = fe_cnt;
    @(negedge clk);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(4);
    checks++; if (pe_cnt !== p0 + 1) begin errors++; $display("FAIL par_pulse got %0d want %0d", pe_cnt, p0 + 1); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL par_discard got empty %b want 1", empty_o); end
    checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL par_noframe got %0d want %0d", fe_cnt, f0); end
    send_frame(8'h07, 1'b1);
    idle(4);
    checks++; if (data_o !== 8'h07) begin errors++; $display("FAIL par_good_data got %h want 07", data_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL par_good_empty got %b want 0", empty_o); end
    checks++; if (pe_cnt !== p0 + 1) begin errors++; $display("FAIL par_single got %0d want %0d", pe_cnt, p0 + 1); end
    pop();
  endtask
`else
  task automatic test_no_parity();
    checks++; if (pe_cnt !== 0) begin errors++; $display("FAIL noparity_pulses got %0d want 0", pe_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_pop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Byte receiver for the serial link whose transmit side is UartTx; it decodes 8N1 frames on RXD (optionally 8E1) into bytes buffered for the board controller. It sits between the RXD pad and the command/voltage-control logic in the 50 MHz domain, using the same bit period (BPS_PARA clocks per bit) as UartClk/UartTx. It provides glitch-rejecting start detection, mid-bit sampling, framing/parity error reporting and a small show-ahead FIFO with a read-enable handshake.

## Interface
- BPS_PARA, 434, clocks per bit (50 MHz / 115200); must be ≥ 8; bench uses 16
- FIFO_DEPTH, 4, received-byte buffer entries; power of two, ≥ 2
- clk  input  1  system clock (clk_50M domain)
- rstn  input  1  reset; **asynchronous, active-low**
- RXD  input  1  serial line, idle high, asynchronous to clk
- data_o  output  8  FIFO head byte; valid while empty_o = 0
- empty_o  output  1  FIFO empty
- rd_en_i  input  1  pop head on this cycle; ignored when empty_o = 1
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- parity_err_o  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out)
- overflow_o  output  1  one-cycle pulse: good byte dropped, FIFO full
- busy_o  output  1  high whenever the FSM is not IDLE

## Operation
- RXD passes through a 2-FF synchroniser (reset value 1); all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HIGH.
- IDLE: rxs falls 1→0 → START; bit timer cleared.
- START: at half a bit (timer = BPS_PARA/2 − 1), if rxs = 0 → DATA, else (glitch) → IDLE with no error.
- DATA: 8 samples, each one full bit period after the previous, LSB first, shifted into an 8-bit register; after bit 7 → PARITY or STOP.
- PARITY: sample; even parity over data + parity bit; a mismatch marks the byte bad → STOP.
- STOP: sample. If rxs = 1 and byte good → push, → IDLE. If rxs = 0 → frame_err_o, discard, → WAIT_HIGH. If parity bad and stop good → parity_err_o, discard, → IDLE. Frame and parity error together → only frame_err_o.
- WAIT_HIGH: remain until rxs = 1, then → IDLE (no false start on a held-low line/break).
- FIFO: show-ahead, FIFO_DEPTH entries, wrapping read/write pointers plus an occupancy counter of $clog2(FIFO_DEPTH)+1 bits. Push when full and no pop → byte dropped, overflow_o pulse, contents unchanged. Push and pop in the same cycle when full → both occur, no overflow. Push and pop when holding one entry → new byte becomes head, empty_o stays 0.

## Timing
- Reset: FSM IDLE, timers/counters 0, data_o = 8'h00, empty_o = 1, all pulse outputs 0, busy_o = 0, synchroniser = 1. Reset asserted mid-frame aborts it; no byte or error is produced.
- Let T be the cycle in which IDLE sees the falling edge on rxs (two clocks after the RXD pin edge). Sample k is taken at T + BPS_PARA/2 + k·BPS_PARA, where k = 0 is start, 1–8 are data, and 9 is stop (with parity, 9 is parity and 10 is stop).
- The FSM is in IDLE the cycle after the stop sample. A start edge arriving anywhere in the second half of the stop bit is accepted, so back-to-back frames are supported.
- Pushed byte: data_o updates and empty_o falls one cycle after the stop sample. frame_err_o, parity_err_o and overflow_o fire in that same cycle.
- rd_en_i: sampled on a clock edge; the next head (or empty_o = 1) appears the following cycle.

## Configuration
- UART_RX_PARITY_EN defined: 11-bit frames (start, 8 data, even parity, stop); PARITY state and parity_err_o are active.
- Not defined: 10-bit 8N1 frames matching UartTx; the PARITY state is absent and parity_err_o is tied 0.

## Test plan
All scenarios use BPS_PARA = 16 and FIFO_DEPTH = 4.
- Reset, then send 8'hA5 → empty_o falls exactly 1 cycle after the stop sample (T + 8 + 9·16), data_o = 8'hA5, no error pulses; rd_en_i for 1 cycle → empty_o = 1.
- RXD low for 5 clocks in idle → FSM returns to IDLE, no byte, no errors, busy_o drops.
- Frame 8'h3C with stop bit forced low, line held low 100 clocks, then high, then 8'h81 → one frame_err_o pulse, no byte from the first frame, then 8'h81 received.
- Five back-to-back bytes 8'h01–8'h05 with no reads → FIFO holds 01–04 and 8'h05 raises overflow_o once; popping returns 01, 02, 03, 04, then empty_o = 1.
- FIFO full, rd_en_i asserted in the push cycle of an incoming byte 8'h77 → no overflow_o, 8'h77 is last out.
- UART_RX_PARITY_EN: send 8'h07 with parity bit 0 (wrong) → parity_err_o pulse, no byte; then send with parity bit 1 → byte 8'h07 received.
